// File: rtl/hex_entry_register.sv
// ---------------------------------------------------------------------------
// hex_entry_register
//
// Collects DIGITS nibbles from a debounced keypad/switch front end into one
// DIGITS*DIGIT_W-bit entry word. It supports backspace, synchronous clear,
// two fill orders and two overflow policies. A commit strobe latches the
// finished word for the downstream display/ALU datapath.
//
// Parameters
//   DIGITS   number of digit slots (>= 2)
//   DIGIT_W  bits per digit
//   MODE     0 = positional fill, MSD slot first; 1 = shift in at the LSD
//   WRAP     0 = ignore loads when full; 1 = accept loads when full
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous, active-high
//   digit_in    digit value, sampled on a load event
//   load        level strobe; a rising edge enters digit_in
//   back        level strobe; a rising edge removes the last digit
//   clr         synchronous clear, level-sensitive, highest priority
//   commit      level strobe; a rising edge latches the entry into word
//   value       live entry word
//   count       number of digits held, 0..DIGITS
//   full        count == DIGITS (combinational)
//   drop        one-cycle pulse: load ignored because full and WRAP=0
//   word        last committed word
//   word_valid  one-cycle pulse when word updates
// ---------------------------------------------------------------------------
module hex_entry_register #(
    parameter int DIGITS  = 4,
    parameter int DIGIT_W = 4,
    parameter int MODE    = 0,
    parameter int WRAP    = 1,
    localparam int VW     = DIGITS * DIGIT_W,
    localparam int CW     = $clog2(DIGITS + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [DIGIT_W-1:0] digit_in,
    input  logic               load,
    input  logic               back,
    input  logic               clr,
    input  logic               commit,
    output logic [VW-1:0]      value,
    output logic [CW-1:0]      count,
    output logic               full,
    output logic               drop,
    output logic [VW-1:0]      word,
    output logic               word_valid
);

    localparam int            PW         = $clog2(DIGITS);
    localparam logic [PW-1:0] LAST_SLOT  = PW'(DIGITS - 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DIGITS);

    // Edge-detect history for the three strobes.
    logic load_q;
    logic back_q;
    logic commit_q;

    logic ld_ev;
    logic bk_ev;
    logic cm_ev;

    // Positional write index: number of slots filled since the last wrap,
    // kept modulo DIGITS so that a full register points back at the MSD.
    logic [PW-1:0] pslot;
    logic [PW-1:0] pslot_inc;
    logic [PW-1:0] pslot_dec;
    logic [PW-1:0] wr_slot;
    logic [PW-1:0] bk_slot;

    logic [VW-1:0] value_nxt;
    logic [CW-1:0] count_nxt;
    logic [PW-1:0] pslot_nxt;
    logic          drop_nxt;

    assign ld_ev = load   & ~load_q;
    assign bk_ev = back   & ~back_q;
    assign cm_ev = commit & ~commit_q;

    assign full = (count == FULL_COUNT);

    assign pslot_inc = (pslot == LAST_SLOT) ? '0 : pslot + PW'(1);
    assign pslot_dec = (pslot == '0) ? LAST_SLOT : pslot - PW'(1);

    // Slot DIGITS-1 is the most-significant digit, so slot index runs
    // opposite to pslot.
    assign wr_slot = LAST_SLOT - pslot;
    assign bk_slot = LAST_SLOT - pslot_dec;

    // Next-state entry logic. Priority: clr, then backspace, then load.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // leaves one unassigned and no latch is inferred.
        value_nxt = value;
        count_nxt = count;
        pslot_nxt = pslot;
        drop_nxt  = 1'b0;

        if (clr) begin
            value_nxt = '0;
            count_nxt = '0;
            pslot_nxt = '0;
        end else if (bk_ev) begin
            // A coincident load is discarded silently (no drop pulse).
            if (count != '0) begin
                count_nxt = count - CW'(1);
                if (MODE == 0) begin
                    pslot_nxt = pslot_dec;
                    value_nxt[int'(bk_slot) * DIGIT_W +: DIGIT_W] = '0;
                end else begin
                    value_nxt = value >> DIGIT_W;
                end
            end
        end else if (ld_ev) begin
            if (full && (WRAP == 0)) begin
                drop_nxt = 1'b1;
            end else begin
                if (!full) begin
                    count_nxt = count + CW'(1);
                end
                if (MODE == 0) begin
                    // When full with WRAP=1, pslot has wrapped to 0, so the
                    // write lands in the MSD slot and the others are kept.
                    value_nxt[int'(wr_slot) * DIGIT_W +: DIGIT_W] = digit_in;
                    pslot_nxt = pslot_inc;
                end else begin
                    value_nxt = {value[VW-DIGIT_W-1:0], digit_in};
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // Edge history resets high: a strobe already held at reset
            // release must not count as a rising edge.
            load_q     <= 1'b1;
            back_q     <= 1'b1;
            commit_q   <= 1'b1;
            value      <= '0;
            count      <= '0;
            pslot      <= '0;
            drop       <= 1'b0;
            word       <= '0;
            word_valid <= 1'b0;
        end else begin
            // Edge history tracks the inputs every cycle, clr or not.
            load_q     <= load;
            back_q     <= back;
            commit_q   <= commit;
            value      <= value_nxt;
            count      <= count_nxt;
            pslot      <= pslot_nxt;
            drop       <= drop_nxt;
            word_valid <= cm_ev;
            // Commit captures the post-update entry, including any
            // same-cycle load, backspace or clear.
            if (cm_ev) begin
                word <= value_nxt;
            end
        end
    end

endmodule

// File: tb/tb_hex_entry_register.sv
// ---------------------------------------------------------------------------
// tb_hex_entry_register
//
// Self-checking bench for hex_entry_register. Three instances share one
// stimulus stream: dut0 (defaults: positional, wrap), dut_nw (positional,
// no wrap) and dut_sh (shift-in, wrap). Expected results are queued when
// the stimulus is driven and popped when the outputs are sampled.
// ---------------------------------------------------------------------------
module tb_hex_entry_register;

    typedef struct packed {
        logic [15:0] value;
        logic [2:0]  count;
        logic        full;
        logic        drop;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [3:0] digit_in;
    logic       load;
    logic       back;
    logic       clr;
    logic       commit;

    logic [15:0] value0, value_nw, value_sh;
    logic [2:0]  count0, count_nw, count_sh;
    logic        full0, full_nw, full_sh;
    logic        drop0, drop_nw, drop_sh;
    logic [15:0] word0, word_nw, word_sh;
    logic        wv0, wv_nw, wv_sh;

    int errors = 0;
    int checks = 0;

    exp_t        exp_q[$];
    logic [15:0] word_q[$];

    hex_entry_register dut0 (
        .clk(clk), .reset(reset), .digit_in(digit_in), .load(load),
        .back(back), .clr(clr), .commit(commit), .value(value0),
        .count(count0), .full(full0), .drop(drop0), .word(word0),
        .word_valid(wv0)
    );

    hex_entry_register #(.DIGITS(4), .DIGIT_W(4), .MODE(0), .WRAP(0)) dut_nw (
        .clk(clk), .reset(reset), .digit_in(digit_in), .load(load),
        .back(back), .clr(clr), .commit(commit), .value(value_nw),
        .count(count_nw), .full(full_nw), .drop(drop_nw), .word(word_nw),
        .word_valid(wv_nw)
    );

    hex_entry_register #(.DIGITS(4), .DIGIT_W(4), .MODE(1), .WRAP(1)) dut_sh (
        .clk(clk), .reset(reset), .digit_in(digit_in), .load(load),
        .back(back), .clr(clr), .commit(commit), .value(value_sh),
        .count(count_sh), .full(full_sh), .drop(drop_sh), .word(word_sh),
        .word_valid(wv_sh)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    function automatic exp_t observe(input int sel);
        case (sel)
            0:       return exp_t'({value0, count0, full0, drop0});
            1:       return exp_t'({value_nw, count_nw, full_nw, drop_nw});
            default: return exp_t'({value_sh, count_sh, full_sh, drop_sh});
        endcase
    endfunction

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One low cycle (guarantees a fresh rising edge), one cycle with the
    // requested strobes high, then strobes dropped. State is then visible.
    task automatic pulse(input logic ld, input logic bk, input logic cl,
                         input logic cm, input logic [3:0] d);
        load = 1'b0; back = 1'b0; clr = 1'b0; commit = 1'b0;
        tick();
        load = ld; back = bk; clr = cl; commit = cm; digit_in = d;
        tick();
        load = 1'b0; back = 1'b0; clr = 1'b0; commit = 1'b0;
    endtask

    task automatic test_reset();
        exp_t got;
        reset = 1'b1; load = 1'b1; back = 1'b0; clr = 1'b0; commit = 1'b0;
        digit_in = 4'h7;
        tick();
        tick();
        reset = 1'b0;
        tick();
        tick();
        exp_q.push_back('{value: 16'h0, count: 3'd0, full: 1'b0, drop: 1'b0});
        got = observe(0);
        checks++;
        if (got !== exp_q[0]) begin
            errors++;
            $display("FAIL reset_load_held: got value=%h count=%0d full=%b drop=%b expected value=%h count=%0d full=%b drop=%b",
                     got.value, got.count, got.full, got.drop, exp_q[0].value,
                     exp_q[0].count, exp_q[0].full, exp_q[0].drop);
        end
        void'(exp_q.pop_front());
        checks++;
        if ({word0, wv0} !== {16'h0, 1'b0}) begin
            errors++;
            $display("FAIL reset_word: got word=%h valid=%b expected word=0000 valid=0", word0, wv0);
        end
        load = 1'b0;
        tick();
    endtask

    task automatic test_positional_wrap();
        logic [3:0] digits[5] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'hA};
        logic [15:0] vals[5] = '{16'h1000, 16'h1200, 16'h1230, 16'h1234, 16'hA234};
        logic [2:0]  cnts[5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
        exp_t got;
        exp_t want;
        pulse(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back('{value: vals[i], count: cnts[i], full: (cnts[i] == 3'd4), drop: 1'b0});
            pulse(1'b1, 1'b0, 1'b0, 1'b0, digits[i]);
            got  = observe(0);
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL pos_wrap_load%0d: got value=%h count=%0d full=%b drop=%b expected value=%h count=%0d full=%b drop=%b",
                         i, got.value, got.count, got.full, got.drop, want.value,
                         want.count, want.full, want.drop);
            end
        end
    endtask

    task automatic test_positional_drop();
        exp_t got;
        exp_t want;
        pulse(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
        for (int i = 1; i <= 4; i++) pulse(1'b1, 1'b0, 1'b0, 1'b0, 4'(i));
        exp_q.push_back('{value: 16'h1234, count: 3'd4, full: 1'b1, drop: 1'b1});
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 4'h5);
        got  = observe(1);
        want = exp_q.pop_front();
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL nowrap_drop: got value=%h count=%0d full=%b drop=%b expected value=%h count=%0d full=%b drop=%b",
                     got.value, got.count, got.full, got.drop, want.value,
                     want.count, want.full, want.drop);
        end
        tick();
        checks++;
        if (drop_nw !== 1'b0) begin
            errors++;
            $display("FAIL nowrap_drop_width: got drop=%b expected drop=0", drop_nw);
        end
        exp_q.push_back('{value: 16'h1230, count: 3'd3, full: 1'b0, drop: 1'b0});
        pulse(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
        got  = observe(1);
        want = exp_q.pop_front();
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL nowrap_back: got value=%h count=%0d full=%b drop=%b expected value=%h count=%0d full=%b drop=%b",
                     got.value, got.count, got.full, got.drop, want.value,
                     want.count, want.full, want.drop);
        end
    endtask

    task automatic test_shift();
        // Steps: load A, load B, back, back, back (last one has no effect).
        logic        lds[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [3:0]  dig[5]  = '{4'hA, 4'hB, 4'h0, 4'h0, 4'h0};
        logic [15:0] vals[5] = '{16'h000A, 16'h00AB, 16'h000A, 16'h0000, 16'h0000};
        logic [2:0]  cnts[5] = '{3'd1, 3'd2, 3'd1, 3'd0, 3'd0};
        exp_t got;
        exp_t want;
        pulse(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back('{value: vals[i], count: cnts[i], full: 1'b0, drop: 1'b0});
            pulse(lds[i], ~lds[i], 1'b0, 1'b0, dig[i]);
            got  = observe(2);
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL shift_step%0d: got value=%h count=%0d full=%b drop=%b expected value=%h count=%0d full=%b drop=%b",
                         i, got.value, got.count, got.full, got.drop, want.value,
                         want.count, want.full, want.drop);
            end
        end
    endtask

    task automatic test_coincident();
        exp_t got;
        exp_t want;
        pulse(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 4'h1);
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 4'h2);
        // load and back together at count=2: only the backspace applies.
        exp_q.push_back('{value: 16'h1000, count: 3'd1, full: 1'b0, drop: 1'b0});
        exp_q.push_back('{value: 16'h1000, count: 3'd1, full: 1'b0, drop: 1'b0});
        pulse(1'b1, 1'b1, 1'b0, 1'b0, 4'h7);
        for (int s = 0; s < 2; s++) begin
            got  = observe(s);
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL load_back_same_cycle_dut%0d: got value=%h count=%0d full=%b drop=%b expected value=%h count=%0d full=%b drop=%b",
                         s, got.value, got.count, got.full, got.drop, want.value,
                         want.count, want.full, want.drop);
            end
        end
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 4'h1);
        exp_q.push_back('{value: 16'h0000, count: 3'd0, full: 1'b0, drop: 1'b0});
        pulse(1'b1, 1'b0, 1'b1, 1'b0, 4'h9);
        got  = observe(0);
        want = exp_q.pop_front();
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL clr_with_load: got value=%h count=%0d full=%b drop=%b expected value=%h count=%0d full=%b drop=%b",
                     got.value, got.count, got.full, got.drop, want.value,
                     want.count, want.full, want.drop);
        end
    endtask

    task automatic test_commit();
        logic [15:0] want_word;
        pulse(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 4'h1);
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 4'h2);
        word_q.push_back(16'h0123);
        pulse(1'b1, 1'b0, 1'b0, 1'b1, 4'h3);
        checks++;
        if (wv_sh !== 1'b1) begin
            errors++;
            $display("FAIL commit_valid: got word_valid=%b expected word_valid=1", wv_sh);
        end else begin
            want_word = word_q.pop_front();
            if (word_sh !== want_word || value_sh !== 16'h0123) begin
                errors++;
                $display("FAIL commit_word: got word=%h value=%h expected word=%h value=0123",
                         word_sh, value_sh, want_word);
            end
        end
        tick();
        checks++;
        if (wv_sh !== 1'b0 || word_sh !== 16'h0123) begin
            errors++;
            $display("FAIL commit_pulse_width: got word_valid=%b word=%h expected word_valid=0 word=0123",
                     wv_sh, word_sh);
        end
        // Commit of an empty entry still latches and pulses.
        pulse(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
        word_q.push_back(16'h0000);
        pulse(1'b0, 1'b0, 1'b0, 1'b1, 4'h0);
        checks++;
        if (wv_sh !== 1'b1) begin
            errors++;
            $display("FAIL commit_empty_valid: got word_valid=%b expected word_valid=1", wv_sh);
        end else begin
            want_word = word_q.pop_front();
            if (word_sh !== want_word || count_sh !== 3'd0) begin
                errors++;
                $display("FAIL commit_empty_word: got word=%h count=%0d expected word=%h count=0",
                         word_sh, count_sh, want_word);
            end
        end
    endtask

    task automatic test_async_reset();
        pulse(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 4'h5);
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 4'h6);
        pulse(1'b0, 1'b0, 1'b0, 1'b1, 4'h0);
        checks++;
        if (word0 !== 16'h5600 || value0 !== 16'h5600 || count0 !== 3'd2) begin
            errors++;
            $display("FAIL pre_reset_entry: got word=%h value=%h count=%0d expected word=5600 value=5600 count=2",
                     word0, value0, count0);
        end
        // Assert reset between edges; outputs must clear before the next edge.
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if ({value0, count0, full0, drop0, word0, wv0, value_sh, word_sh} !== '0) begin
            errors++;
            $display("FAIL async_reset: got value=%h count=%0d full=%b drop=%b word=%h valid=%b sh_value=%h sh_word=%h expected all zero",
                     value0, count0, full0, drop0, word0, wv0, value_sh, word_sh);
        end
        #2;
        reset = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_positional_wrap();
        test_positional_drop();
        test_shift();
        test_coincident();
        test_commit();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
